// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 32-bit combinational ALU between two requesters.
// A request is granted in IDLE, its operands are latched, the ALU is evaluated
// in EXEC, and the registered result is held in RESP until the owner takes it.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (port 0 always wins a tie;
// the round-robin pointer is then neither consulted nor updated).
module alu_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        ptr;
  logic        owner;
  logic        grant;
  logic        hs;
  logic        owner_ready;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [3:0]  op_q;
  logic [31:0] alu_y;

  // Pick the port that would win if both were asking; a lone requester always wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end else begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ptr;
`endif
    end
  end

  assign req0_ready  = (state == IDLE) && req0_valid && (grant == 1'b0);
  assign req1_ready  = (state == IDLE) && req1_valid && (grant == 1'b1);
  assign hs          = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign owner_ready = owner ? rsp1_ready : rsp0_ready;

  // Shared ALU, fed only from the operands latched at the handshake.
  always_comb begin
    alu_y = '0;
    case (op_q)
      4'b0000: alu_y = a_q & b_q;
      4'b0001: alu_y = a_q | b_q;
      4'b0010: alu_y = a_q + b_q;
      4'b0110: alu_y = a_q - b_q;
      default: alu_y = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: accept -> evaluate -> hold response until the owner consumes it.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (hs) state_nx = EXEC;
      EXEC:    state_nx = RESP;
      RESP:    if (owner_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, pointer update and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr        <= RR_INIT;
      owner      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            owner <= grant;
            a_q   <= grant ? req1_a  : req0_a;
            b_q   <= grant ? req1_b  : req0_b;
            op_q  <= grant ? req1_op : req0_op;
`ifndef ALU_ARB_FIXED_PRIO_EN
            ptr   <= ~grant;
`endif
          end
        end
        EXEC: begin
          rsp_result <= alu_y;
          rsp_zero   <= (alu_y == '0);
          if (owner) rsp1_valid <= 1'b1;
          else       rsp0_valid <= 1'b1;
        end
        RESP: begin
          if (owner_ready) begin
            if (owner) rsp1_valid <= 1'b0;
            else       rsp0_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios followed by randomized traffic, all checked
// cycle by cycle against a transaction-level reference model of the arbiter.
// Honours ALU_ARB_FIXED_PRIO_EN in the model when the build defines it.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_op, req1_op;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // model: one in-flight operation with its age since acceptance
  bit          m_busy;
  int unsigned m_age;
  bit          m_owner;
  bit          m_ptr;
  logic [31:0] m_res;
  bit          m_rv0, m_rv1;
  logic [31:0] m_result;
  bit          m_zero;

  bit acc0, acc1;
  bit keep;

  alu_arbiter #(.RR_INIT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit pick(input bit v0, input bit v1);
    if (v0 && !v1) return 1'b0;
    if (v1 && !v0) return 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    return 1'b0;
`else
    return m_ptr;
`endif
  endfunction

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_owner = 0; m_ptr = 1'b0; m_res = '0;
    m_rv0 = 0; m_rv1 = 0; m_result = '0; m_zero = 0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    bit g, er0, er1, hs0, hs1, r0, r1;
    @(negedge clk);
    g   = pick(req0_valid, req1_valid);
    er0 = !m_busy && req0_valid && (g == 1'b0);
    er1 = !m_busy && req1_valid && (g == 1'b1);
    check_eq("req0_ready", {31'd0, req0_ready}, {31'd0, er0});
    check_eq("req1_ready", {31'd0, req1_ready}, {31'd0, er1});
    check_eq("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, m_rv0});
    check_eq("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, m_rv1});
    check_eq("rsp_result", rsp_result, m_result);
    check_eq("rsp_zero", {31'd0, rsp_zero}, {31'd0, m_zero});
    hs0 = req0_valid && er0;
    hs1 = req1_valid && er1;
    r0  = rsp0_ready;
    r1  = rsp1_ready;
    acc0 = hs0;
    acc1 = hs1;
    @(posedge clk);
    if (m_busy && m_age == 1) begin
      if (m_owner ? r1 : r0) begin
        m_busy = 0;
        if (m_owner) m_rv1 = 0; else m_rv0 = 0;
      end
    end else if (m_busy && m_age == 0) begin
      m_age    = 1;
      m_result = m_res;
      m_zero   = (m_res == 32'd0);
      if (m_owner) m_rv1 = 1; else m_rv0 = 1;
    end else if (hs0 || hs1) begin
      m_busy  = 1;
      m_age   = 0;
      m_owner = hs1;
      m_res   = hs1 ? ref_alu(req1_a, req1_b, req1_op) : ref_alu(req0_a, req0_b, req0_op);
`ifndef ALU_ARB_FIXED_PRIO_EN
      m_ptr   = ~hs1;
`endif
    end
    #1;
    if (acc0 && !keep) req0_valid = 1'b0;
    if (acc1 && !keep) req1_valid = 1'b0;
  endtask

  task automatic steps(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic issue(input bit port, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op);
    if (port) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  function automatic logic [31:0] rnd_operand();
    if ($urandom_range(1, 0) == 0) return 32'($urandom_range(7, 0));
    return $urandom;
  endfunction

  function automatic logic [3:0] rnd_op();
    logic [3:0] ops [5];
    ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd2; ops[3] = 4'd6; ops[4] = 4'($urandom);
    return ops[$urandom_range(4, 0)];
  endfunction

  initial begin
    rst = 1'b1;
    keep = 0;
    req0_valid = 0; req1_valid = 0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1; rsp1_ready = 1;
    model_reset();

    #12;
    check_eq("reset_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check_eq("reset_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check_eq("reset_result", rsp_result, 32'd0);
    check_eq("reset_zero", {31'd0, rsp_zero}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // single add on port 0, then zero / wrap / undefined-op cases
    issue(0, 32'd5, 32'd3, 4'b0010);
    steps(5);
    issue(1, 32'd7, 32'd7, 4'b0110);
    steps(5);
    issue(1, 32'hFFFF_FFFF, 32'd1, 4'b0010);
    steps(5);
    issue(0, 32'd9, 32'd9, 4'b1111);
    steps(5);

    // contention: both ports asking every cycle
    keep = 1;
    issue(0, 32'h0000_F0F0, 32'h0000_0FF0, 4'b0000);
    issue(1, 32'h0000_F0F0, 32'h0000_0FF0, 4'b0000);
    steps(15);
    keep = 0;
    req0_valid = 0; req1_valid = 0;
    steps(4);

    // backpressure on port 0 while port 1 waits
    rsp0_ready = 0;
    issue(0, 32'h1234_0000, 32'h0000_5678, 4'b0001);
    steps(1);
    issue(1, 32'd1, 32'd2, 4'b0010);
    steps(7);
    rsp0_ready = 1;
    steps(6);

    // reset in EXEC
    issue(1, 32'd40, 32'd2, 4'b0010);
    steps(1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_exec_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    check_eq("rst_exec_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    check_eq("rst_exec_result", rsp_result, 32'd0);
    check_eq("rst_exec_zero", {31'd0, rsp_zero}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    issue(0, 32'd3, 32'd4, 4'b0010);
    issue(1, 32'd6, 32'd1, 4'b0110);
    steps(10);

    // randomized traffic; a request is held until accepted
    for (int unsigned i = 0; i < 3000; i++) begin
      if (!req0_valid && $urandom_range(2, 0) != 0)
        issue(0, rnd_operand(), rnd_operand(), rnd_op());
      if (!req1_valid && $urandom_range(2, 0) != 0)
        issue(1, rnd_operand(), rnd_operand(), rnd_op());
      rsp0_ready = ($urandom_range(3, 0) != 0);
      rsp1_ready = ($urandom_range(3, 0) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
